// File: rtl/counter_ctrl.sv
// counter_ctrl -- bounded up/down run counter with a small run-control FSM.
//
// A run is started from IDLE with start=1; the bounds and mode are latched at
// that edge and stay fixed until the next accepted start. The count then
// walks between lo and hi according to the latched mode:
//   00 wrap-up, 01 wrap-down, 10 bounce, 11 one-shot up.
// stop aborts a run (done pulse), pause freezes it, and an inverted bound
// pair (lo > hi) rejects the start with an err pulse.
//
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   start/stop/pause   run control levels, sampled every edge
//   cfg_lo/cfg_hi      N-bit unsigned bounds, cfg_mode 2-bit mode
//   count, dir         registered count and direction (1 = up)
//   busy               state is UP or DOWN
//   done, err          single-cycle pulses (run end / rejected start)
//   laps               wraps/turnarounds in the current run, saturating at 255
module counter_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic [N-1:0] cfg_lo,
  input  logic [N-1:0] cfg_hi,
  input  logic [1:0]   cfg_mode,
  output logic [N-1:0] count,
  output logic         dir,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [7:0]   laps
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;

  localparam logic [1:0] M_WRAP_UP = 2'b00;
  localparam logic [1:0] M_WRAP_DN = 2'b01;
  localparam logic [1:0] M_BOUNCE  = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         dir_q, dir_d;
  logic [7:0]   laps_q, laps_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N-1:0] hi_q, hi_d;
  logic [1:0]   mode_q, mode_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [7:0]   laps_inc;

  // Saturating lap increment.
  assign laps_inc = (laps_q == 8'hFF) ? laps_q : laps_q + 8'd1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    laps_d  = laps_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_lo <= cfg_hi) begin
            lo_d   = cfg_lo;
            hi_d   = cfg_hi;
            mode_d = cfg_mode;
            laps_d = 8'd0;
            if (cfg_mode == M_WRAP_DN) begin
              state_d = DOWN;
              count_d = cfg_hi;
              dir_d   = 1'b0;
            end else begin
              state_d = UP;
              count_d = cfg_lo;
              dir_d   = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      UP: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (!pause) begin
          if (count_q < hi_q) begin
            count_d = count_q + ONE;
          end else begin
            case (mode_q)
              M_BOUNCE: begin
                state_d = DOWN;
                dir_d   = 1'b0;
                // lo == hi means there is no room to step back: hold.
                count_d = (lo_q == hi_q) ? hi_q : hi_q - ONE;
                laps_d  = laps_inc;
              end
              M_ONESHOT: begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
              default: begin
                count_d = lo_q;
                laps_d  = laps_inc;
              end
            endcase
          end
        end
      end

      DOWN: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (!pause) begin
          if (count_q > lo_q) begin
            count_d = count_q - ONE;
          end else if (mode_q == M_BOUNCE) begin
            state_d = UP;
            dir_d   = 1'b1;
            count_d = (lo_q == hi_q) ? lo_q : lo_q + ONE;
            laps_d  = laps_inc;
          end else begin
            count_d = hi_q;
            laps_d  = laps_inc;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      dir_q   <= 1'b1;
      laps_q  <= 8'd0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= 2'b00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      laps_q  <= laps_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign laps  = laps_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl (N=4). Inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_counter_ctrl;

  logic       clk, rst, start, stop, pause;
  logic [3:0] cfg_lo, cfg_hi;
  logic [1:0] cfg_mode;
  logic [3:0] count;
  logic       dir, busy, done, err;
  logic [7:0] laps;

  int n_chk = 0;
  int n_err = 0;

  counter_ctrl #(.N(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_mode(cfg_mode),
    .count(count), .dir(dir), .busy(busy), .done(done), .err(err),
    .laps(laps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [3:0] lo, input logic [3:0] hi, input logic [1:0] mode);
    cfg_lo = lo; cfg_hi = hi; cfg_mode = mode; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int exp_c[7];
  int exp_d[7];
  int exp_l[7];

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    cfg_lo = '0; cfg_hi = '0; cfg_mode = 2'b00;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_dir",   32'(dir),   1);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_done",  32'(done),  0);
    chk("rst_err",   32'(err),   0);
    chk("rst_laps",  32'(laps),  0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Wrap-up lo=3 hi=5.
    exp_c = '{3, 4, 5, 3, 4, 5, 3};
    exp_l = '{0, 0, 0, 1, 1, 1, 2};
    run_start(4'd3, 4'd5, 2'b00);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk($sformatf("wu_cnt%0d", i),  32'(count), 32'(exp_c[i]));
      chk($sformatf("wu_laps%0d", i), 32'(laps),  32'(exp_l[i]));
      chk($sformatf("wu_busy%0d", i), 32'(busy),  1);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("wu_stop_busy",  32'(busy),  0);
    chk("wu_stop_done",  32'(done),  1);
    chk("wu_stop_count", 32'(count), 3);
    chk("wu_stop_laps",  32'(laps),  2);
    tick();
    chk("wu_done_clr",   32'(done),  0);
    chk("idle_hold_cnt", 32'(count), 3);

    // Bounce lo=2 hi=4; cfg churn and a start pulse mid-run must be ignored.
    exp_c = '{2, 3, 4, 3, 2, 3, 4};
    exp_d = '{1, 1, 1, 0, 0, 1, 1};
    exp_l = '{0, 0, 0, 1, 1, 2, 2};
    run_start(4'd2, 4'd4, 2'b10);
    cfg_lo = 4'd0; cfg_hi = 4'd15; cfg_mode = 2'b11;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      start = (i == 2);
      chk($sformatf("bn_cnt%0d", i),  32'(count), 32'(exp_c[i]));
      chk($sformatf("bn_dir%0d", i),  32'(dir),   32'(exp_d[i]));
      chk($sformatf("bn_laps%0d", i), 32'(laps),  32'(exp_l[i]));
    end
    start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("bn_stop_done", 32'(done), 1);
    tick();

    // One-shot lo=0 hi=15.
    run_start(4'd0, 4'd15, 2'b11);
    chk("os_first", 32'(count), 0);
    for (int i = 1; i <= 15; i++) tick();
    chk("os_at_hi",    32'(count), 15);
    chk("os_busy_hi",  32'(busy),  1);
    chk("os_done_pre", 32'(done),  0);
    tick();
    chk("os_end_cnt",  32'(count), 15);
    chk("os_end_done", 32'(done),  1);
    chk("os_end_busy", 32'(busy),  0);
    tick();
    chk("os_done_clr", 32'(done),  0);
    chk("os_hold_cnt", 32'(count), 15);

    // Wrap-down lo=0 hi=3 with pause at 2, then stop.
    run_start(4'd0, 4'd3, 2'b01);
    chk("wd_first_cnt", 32'(count), 3);
    chk("wd_first_dir", 32'(dir),   0);
    tick();
    chk("wd_cnt2", 32'(count), 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wd_pause%0d", i), 32'(count), 2);
      chk($sformatf("wd_pbusy%0d", i), 32'(busy),  1);
    end
    pause = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    chk("wd_stop_done", 32'(done),  1);
    chk("wd_stop_cnt",  32'(count), 2);
    chk("wd_stop_busy", 32'(busy),  0);
    chk("wd_stop_laps", 32'(laps),  0);
    tick();

    // Rejected start lo=6 hi=2.
    run_start(4'd6, 4'd2, 2'b00);
    chk("rej_err",  32'(err),   1);
    chk("rej_busy", 32'(busy),  0);
    chk("rej_cnt",  32'(count), 2);
    tick();
    chk("rej_err_clr", 32'(err), 0);

    // Degenerate bounce lo=hi=7: lap every cycle, saturating.
    run_start(4'd7, 4'd7, 2'b10);
    chk("dg_first_laps", 32'(laps), 0);
    tick();
    chk("dg_laps1", 32'(laps),  1);
    chk("dg_cnt1",  32'(count), 7);
    chk("dg_dir1",  32'(dir),   0);
    tick();
    chk("dg_laps2", 32'(laps),  2);
    chk("dg_dir2",  32'(dir),   1);
    for (int i = 2; i < 255; i++) tick();
    chk("dg_laps255", 32'(laps), 255);
    for (int i = 0; i < 10; i++) tick();
    chk("dg_sat",     32'(laps),  255);
    chk("dg_sat_cnt", 32'(count), 7);
    stop = 1'b1; tick(); stop = 1'b0;
    tick();

    // Async reset mid-run at count 9.
    run_start(4'd0, 4'd12, 2'b00);
    for (int i = 0; i < 9; i++) tick();
    chk("ar_pre_cnt", 32'(count), 9);
    #2 rst = 1'b1;
    #1;
    chk("ar_cnt",  32'(count), 0);
    chk("ar_busy", 32'(busy),  0);
    chk("ar_dir",  32'(dir),   1);
    chk("ar_laps", 32'(laps),  0);
    chk("ar_done", 32'(done),  0);
    #1 rst = 1'b0;
    tick();
    chk("ar_no_done", 32'(done), 0);
    run_start(4'd1, 4'd2, 2'b00);
    chk("ar_run0", 32'(count), 1);
    tick();
    chk("ar_run1", 32'(count), 2);
    tick();
    chk("ar_run2", 32'(count), 1);
    chk("ar_laps", 32'(laps),  1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
